// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter state encoding and channel ids shared by the burst arbiter files
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_ZLEN = 2'd3
    } state_t;

    localparam logic CH_WR = 1'b0;
    localparam logic CH_RD = 1'b1;

endpackage

// File: rtl/mem_burst_arbiter_if.sv
// mem_burst_arbiter_if: one burst port carrying a write and a read channel; master issues bursts, slave serves them
interface mem_burst_arbiter_if #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 28,
    parameter int BUSRT_BITS    = 10
);

    logic                     wr_burst_req;
    logic [BUSRT_BITS-1:0]    wr_burst_len;
    logic [ADDR_BITS-1:0]     wr_burst_addr;
    logic                     wr_burst_data_req;
    logic [MEM_DATA_BITS-1:0] wr_burst_data;
    logic                     wr_burst_finish;
    logic                     rd_burst_req;
    logic [BUSRT_BITS-1:0]    rd_burst_len;
    logic [ADDR_BITS-1:0]     rd_burst_addr;
    logic                     rd_burst_data_valid;
    logic [MEM_DATA_BITS-1:0] rd_burst_data;
    logic                     rd_burst_finish;

    modport master (
        output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
        output rd_burst_req, rd_burst_len, rd_burst_addr,
        input  wr_burst_data_req, wr_burst_finish,
        input  rd_burst_data_valid, rd_burst_data, rd_burst_finish
    );

    modport slave (
        input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
        input  rd_burst_req, rd_burst_len, rd_burst_addr,
        output wr_burst_data_req, wr_burst_finish,
        output rd_burst_data_valid, rd_burst_data, rd_burst_finish
    );

endinterface

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: two-way round-robin picker; with WR_PRIORITY_EN defined the write channel wins every tie
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef WR_PRIORITY_EN
    assign grant[CH_WR] = req[CH_WR];
    assign grant[CH_RD] = req[CH_RD] & ~req[CH_WR];
`else
    assign grant[CH_WR] = req[CH_WR] & (~req[CH_RD] | (last_grant == CH_RD));
    assign grant[CH_RD] = req[CH_RD] & (~req[CH_WR] | (last_grant == CH_WR));
`endif

endmodule

// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: shares the memory burst port between camera write and display read channels, one burst at a time (WR_PRIORITY_EN: write wins ties)
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 28,
    parameter int BUSRT_BITS    = 10
) (
    input  logic                mem_clk,
    input  logic                rst,
    mem_burst_arbiter_if.slave  s,
    mem_burst_arbiter_if.master m,
    output logic                arb_busy
);

    state_t     state;
    logic       last_grant;
    logic       gnt_ch;
    logic [1:0] req;
    logic [1:0] grant;
    logic       wr_zero;
    logic       rd_zero;

    assign req     = {s.rd_burst_req, s.wr_burst_req};
    assign wr_zero = s.wr_burst_len == BUSRT_BITS'(0);
    assign rd_zero = s.rd_burst_len == BUSRT_BITS'(0);

    mem_arb_rr2 u_rr2 (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // grant in IDLE, hold the granted burst until its finish, zero-length grants spend one cycle in ZLEN
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state           <= S_IDLE;
            last_grant      <= CH_RD;
            gnt_ch          <= CH_WR;
            m.wr_burst_req  <= 1'b0;
            m.wr_burst_len  <= '0;
            m.wr_burst_addr <= '0;
            m.rd_burst_req  <= 1'b0;
            m.rd_burst_len  <= '0;
            m.rd_burst_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant[CH_WR]) begin
                        last_grant      <= CH_WR;
                        gnt_ch          <= CH_WR;
                        m.wr_burst_len  <= s.wr_burst_len;
                        m.wr_burst_addr <= ADDR_BITS'(s.wr_burst_addr);
                        m.wr_burst_req  <= ~wr_zero;
                        state           <= wr_zero ? S_ZLEN : S_WR;
                    end else if (grant[CH_RD]) begin
                        last_grant      <= CH_RD;
                        gnt_ch          <= CH_RD;
                        m.rd_burst_len  <= s.rd_burst_len;
                        m.rd_burst_addr <= ADDR_BITS'(s.rd_burst_addr);
                        m.rd_burst_req  <= ~rd_zero;
                        state           <= rd_zero ? S_ZLEN : S_RD;
                    end
                end
                S_WR: begin
                    if (m.wr_burst_finish) begin
                        m.wr_burst_req <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                S_RD: begin
                    if (m.rd_burst_finish) begin
                        m.rd_burst_req <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign arb_busy            = state != S_IDLE;
    assign m.wr_burst_data     = MEM_DATA_BITS'(s.wr_burst_data);
    assign s.wr_burst_data_req = m.wr_burst_data_req & (state == S_WR);
    assign s.rd_burst_data_valid = m.rd_burst_data_valid & (state == S_RD);
    assign s.rd_burst_data     = m.rd_burst_data;
    assign s.wr_burst_finish   = ((state == S_WR) & m.wr_burst_finish) | ((state == S_ZLEN) & (gnt_ch == CH_WR));
    assign s.rd_burst_finish   = ((state == S_RD) & m.rd_burst_finish) | ((state == S_ZLEN) & (gnt_ch == CH_RD));

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb_mem_burst_arbiter: randomized rounds against a grant-order model, scoreboard monitor checks bursts, data steering and reset
module tb_mem_burst_arbiter;

`ifdef WR_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arb_busy;

    always #5 clk = ~clk;

    mem_burst_arbiter_if s_if ();
    mem_burst_arbiter_if m_if ();

    mem_burst_arbiter dut (
        .mem_clk  (clk),
        .rst      (rst),
        .s        (s_if),
        .m        (m_if),
        .arb_busy (arb_busy)
    );

    typedef struct {
        int len;
        int addr;
        bit solo;
        int t0;
    } txn_t;

    txn_t wr_todo[$], rd_todo[$], wr_exp[$], rd_exp[$];
    bit   exp_gnt[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   last_win = 1'b1;
    bit   spur_wr = 1'b0;
    bit   spur_rd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    initial begin : wr_data_drv
        s_if.wr_burst_data = '0;
        forever begin
            @(posedge clk);
            #1 s_if.wr_burst_data = $urandom;
        end
    end

    initial begin : wr_requester
        txn_t t;
        int   n;
        s_if.wr_burst_req  = 1'b0;
        s_if.wr_burst_len  = '0;
        s_if.wr_burst_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (wr_todo.size() != 0 && !rst) begin
                t = wr_todo.pop_front();
                t.t0 = cyc;
                s_if.wr_burst_len  = 10'(t.len);
                s_if.wr_burst_addr = 28'(t.addr);
                s_if.wr_burst_req  = 1'b1;
                wr_exp.push_back(t);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                    if (m_if.wr_burst_req) begin
                        s_if.wr_burst_len  = 10'($urandom);
                        s_if.wr_burst_addr = 28'($urandom);
                    end
                end while (!s_if.wr_burst_finish && !rst && n < 3000);
                if (n >= 3000) chk("wr_finish_timeout", 0, 1);
                @(posedge clk);
                #1 s_if.wr_burst_req = 1'b0;
            end
        end
    end

    initial begin : rd_requester
        txn_t t;
        int   n;
        s_if.rd_burst_req  = 1'b0;
        s_if.rd_burst_len  = '0;
        s_if.rd_burst_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_todo.size() != 0 && !rst) begin
                t = rd_todo.pop_front();
                t.t0 = cyc;
                s_if.rd_burst_len  = 10'(t.len);
                s_if.rd_burst_addr = 28'(t.addr);
                s_if.rd_burst_req  = 1'b1;
                rd_exp.push_back(t);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                    if (m_if.rd_burst_req) begin
                        s_if.rd_burst_len  = 10'($urandom);
                        s_if.rd_burst_addr = 28'($urandom);
                    end
                end while (!s_if.rd_burst_finish && !rst && n < 3000);
                if (n >= 3000) chk("rd_finish_timeout", 0, 1);
                @(posedge clk);
                #1 s_if.rd_burst_req = 1'b0;
            end
        end
    end

    initial begin : mem_model
        int n, i;
        bit is_rd, inj, beat, sp;
        m_if.wr_burst_data_req   = 1'b0;
        m_if.wr_burst_finish     = 1'b0;
        m_if.rd_burst_data_valid = 1'b0;
        m_if.rd_burst_data       = '0;
        m_if.rd_burst_finish     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && (m_if.wr_burst_req || m_if.rd_burst_req)) begin
                is_rd = m_if.rd_burst_req;
                n = is_rd ? int'(m_if.rd_burst_len) : int'(m_if.wr_burst_len);
                i = 0;
                inj = 1'b0;
                while (i < n && !rst) begin
                    beat = $urandom_range(0, 3) != 0;
                    sp = !inj && i == 3;
                    inj |= sp;
                    if (is_rd) begin
                        m_if.rd_burst_data_valid = beat;
                        m_if.rd_burst_data = beat ? 32'(m_if.rd_burst_addr) + 32'(i) : $urandom;
                        m_if.wr_burst_data_req = sp;
                        m_if.wr_burst_finish = sp;
                        spur_wr = sp;
                    end else begin
                        m_if.wr_burst_data_req = beat;
                        m_if.rd_burst_data_valid = sp;
                        m_if.rd_burst_finish = sp;
                        spur_rd = sp;
                    end
                    if (beat) i++;
                    @(posedge clk);
                    #1;
                end
                m_if.wr_burst_data_req   = 1'b0;
                m_if.wr_burst_finish     = 1'b0;
                m_if.rd_burst_data_valid = 1'b0;
                m_if.rd_burst_finish     = 1'b0;
                spur_wr = 1'b0;
                spur_rd = 1'b0;
                if (!rst) begin
                    if (is_rd) m_if.rd_burst_finish = 1'b1;
                    else m_if.wr_burst_finish = 1'b1;
                    @(posedge clk);
                    #1;
                    m_if.wr_burst_finish = 1'b0;
                    m_if.rd_burst_finish = 1'b0;
                end
            end
        end
    end

    txn_t cw, cr;
    bit   wa = 1'b0;
    bit   ra = 1'b0;
    int   wb = 0;
    int   rb = 0;

    task automatic grant_event(input bit ch);
        if (exp_gnt.size() == 0) chk("grant_unexpected", {63'd0, ch}, 64'd2);
        else chk("grant_order", {63'd0, ch}, {63'd0, exp_gnt.pop_front()});
        chk("busy_on_grant", arb_busy, 1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            wa = 1'b0;
            ra = 1'b0;
        end else begin
            if (m_if.wr_burst_req && !wa) begin
                wa = 1'b1;
                wb = 0;
                grant_event(1'b0);
                chk("wr_excl", m_if.rd_burst_req, 0);
                if (wr_exp.size() == 0) chk("wr_burst_unexpected", 1, 0);
                else begin
                    cw = wr_exp.pop_front();
                    chk("wr_mreq_nonzero_len", cw.len != 0, 1);
                    chk("wr_len", m_if.wr_burst_len, cw.len);
                    chk("wr_addr", m_if.wr_burst_addr, cw.addr);
                    if (cw.solo) chk("wr_grant_latency", cyc - cw.t0, 1);
                end
            end
            if (m_if.rd_burst_req && !ra) begin
                ra = 1'b1;
                rb = 0;
                grant_event(1'b1);
                chk("rd_excl", m_if.wr_burst_req, 0);
                if (rd_exp.size() == 0) chk("rd_burst_unexpected", 1, 0);
                else begin
                    cr = rd_exp.pop_front();
                    chk("rd_mreq_nonzero_len", cr.len != 0, 1);
                    chk("rd_len", m_if.rd_burst_len, cr.len);
                    chk("rd_addr", m_if.rd_burst_addr, cr.addr);
                    if (cr.solo) chk("rd_grant_latency", cyc - cr.t0, 1);
                end
            end
            if (spur_wr) begin
                chk("spur_wr_finish", s_if.wr_burst_finish, 0);
                chk("spur_wr_data_req", s_if.wr_burst_data_req, 0);
                chk("spur_wr_rd_held", m_if.rd_burst_req, 1);
            end
            if (spur_rd) begin
                chk("spur_rd_finish", s_if.rd_burst_finish, 0);
                chk("spur_rd_valid", s_if.rd_burst_data_valid, 0);
                chk("spur_rd_wr_held", m_if.wr_burst_req, 1);
            end
            if (s_if.wr_burst_data_req) begin
                chk("wr_data_pass", m_if.wr_burst_data, s_if.wr_burst_data);
                wb++;
            end
            if (s_if.rd_burst_data_valid) begin
                chk("rd_data", s_if.rd_burst_data, 32'(cr.addr + rb));
                rb++;
            end
            if (s_if.wr_burst_finish) begin
                if (wa) begin
                    chk("wr_beats", wb, cw.len);
                    chk("wr_len_hold", m_if.wr_burst_len, cw.len);
                    chk("wr_addr_hold", m_if.wr_burst_addr, cw.addr);
                    wa = 1'b0;
                end else begin
                    grant_event(1'b0);
                    if (wr_exp.size() == 0) chk("wr_finish_unexpected", 1, 0);
                    else begin
                        cw = wr_exp.pop_front();
                        chk("wr_zlen_len", cw.len, 0);
                        if (cw.solo) chk("wr_zlen_latency", cyc - cw.t0, 1);
                    end
                end
            end
            if (s_if.rd_burst_finish) begin
                if (ra) begin
                    chk("rd_beats", rb, cr.len);
                    chk("rd_len_hold", m_if.rd_burst_len, cr.len);
                    chk("rd_addr_hold", m_if.rd_burst_addr, cr.addr);
                    ra = 1'b0;
                end else begin
                    grant_event(1'b1);
                    if (rd_exp.size() == 0) chk("rd_finish_unexpected", 1, 0);
                    else begin
                        cr = rd_exp.pop_front();
                        chk("rd_zlen_len", cr.len, 0);
                        if (cr.solo) chk("rd_zlen_latency", cyc - cr.t0, 1);
                    end
                end
            end
        end
    end

    task automatic round(input bit w, input bit r, input int wl, input int rl, input int wad, input int rad);
        txn_t t;
        bit   first;
        int   n;
        @(negedge clk);
        if (w) begin
            t.len = wl;
            t.addr = wad;
            t.solo = !r;
            t.t0 = 0;
            wr_todo.push_back(t);
        end
        if (r) begin
            t.len = rl;
            t.addr = rad;
            t.solo = !w;
            t.t0 = 0;
            rd_todo.push_back(t);
        end
        if (w && r) begin
            first = PRIO ? 1'b0 : !last_win;
            exp_gnt.push_back(first);
            exp_gnt.push_back(!first);
            last_win = !first;
        end else if (w || r) begin
            exp_gnt.push_back(r);
            last_win = r;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((wr_todo.size() != 0 || rd_todo.size() != 0 || s_if.wr_burst_req || s_if.rd_burst_req || arb_busy) && n < 4000);
        chk("round_done", n < 4000, 1);
        chk("grants_consumed", exp_gnt.size(), 0);
    endtask

    function automatic int rlen();
        return ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 24));
    endfunction

    function automatic int raddr();
        return int'($urandom & 32'h0FFF_FFFF);
    endfunction

    initial begin : stimulus
        int n, kind;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", arb_busy, 0);
        chk("rst_wr_mreq", m_if.wr_burst_req, 0);
        chk("rst_rd_mreq", m_if.rd_burst_req, 0);
        chk("rst_wr_len_addr", {m_if.wr_burst_len, m_if.wr_burst_addr}, 0);
        chk("rst_rd_len_addr", {m_if.rd_burst_len, m_if.rd_burst_addr}, 0);
        chk("rst_s_strobes", {s_if.wr_burst_finish, s_if.rd_burst_finish, s_if.wr_burst_data_req, s_if.rd_burst_data_valid}, 0);
        rst = 1'b0;
        round(1, 0, 128, 0, 'h100, 0);
        round(1, 1, 8, 8, 'h200, 'h300);
        round(0, 1, 0, 16, 0, 'h3000);
        round(1, 1, 6, 6, 'h400, 'h500);
        round(1, 0, 0, 0, 'h600, 0);
        round(1, 1, 0, 5, 'h700, 'h800);
        round(0, 1, 0, 0, 0, 'h900);
        for (int k = 0; k < 24; k++) begin
            kind = int'($urandom_range(0, 2));
            round(kind != 1, kind != 0, rlen(), rlen(), raddr(), raddr());
        end
        @(negedge clk);
        begin
            txn_t t;
            t.len = 128;
            t.addr = 'h2000;
            t.solo = 1'b1;
            t.t0 = 0;
            rd_todo.push_back(t);
        end
        exp_gnt.push_back(1'b1);
        n = 0;
        while (!(ra && rb >= 40) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_burst_reached", ra && rb >= 40, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", arb_busy, 0);
        chk("midrst_rd_mreq", m_if.rd_burst_req, 0);
        chk("midrst_rd_len_addr", {m_if.rd_burst_len, m_if.rd_burst_addr}, 0);
        chk("midrst_rd_strobes", {s_if.rd_burst_finish, s_if.rd_burst_data_valid}, 0);
        @(negedge clk);
        rst = 1'b0;
        wr_exp.delete();
        rd_exp.delete();
        exp_gnt.delete();
        last_win = 1'b1;
        round(1, 1, 4, 4, 'h40, 'h80);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
